fir_ctrl: RTL and testbench

Control/status and sequencing block for the FIR engine. Terminates the AXI-Lite configuration port and decodes the register map: ap_ctrl, data_length, and a tap-coefficient window. Owns the tap BRAM port and hands it to the engine only while a run is active. Starts the engine, counts accepted output samples, and raises ap_done and tlast at the programmed length.

---
 rtl/fir_pkg.sv | 34 +++
 rtl/fir_ctrl_axil.sv | 93 +++++++++
 rtl/fir_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_fir_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR control block: register offsets, ap_ctrl bit
// positions, sequencer states and the value returned for blocked tap reads.
package fir_pkg;

    localparam int unsigned REG_AP_CTRL  = 32'h00;
    localparam int unsigned REG_IRQ      = 32'h04;
    localparam int unsigned REG_DATA_LEN = 32'h10;
    localparam int unsigned REG_TAP_BASE = 32'h20;

    localparam int unsigned AP_START_BIT = 0;
    localparam int unsigned AP_DONE_BIT  = 1;
    localparam int unsigned AP_IDLE_BIT  = 2;

    localparam logic [31:0] TAP_BLOCKED_VAL = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fir_state_e;

    // ap_ctrl read value as a function of the sequencer state
    function automatic logic [31:0] ap_ctrl_val(input fir_state_e s);
        logic [31:0] v;
        v = '0;
        case (s)
            ST_IDLE: v[AP_IDLE_BIT] = 1'b1;
            ST_DONE: v[AP_DONE_BIT] = 1'b1;
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/fir_ctrl_axil.sv
// AXI-Lite slave front end: write/read handshakes, decoded strobes for the
// register file, and the rvalid/rdata hold until rready.
module fir_ctrl_axil
    import fir_pkg::*;
#(
    parameter int unsigned pADDR_WIDTH = 12,
    parameter int unsigned pDATA_WIDTH = 32
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [pADDR_WIDTH-1:0] awaddr,
    input  logic                   wvalid,
    output logic                   wready,
    input  logic [pDATA_WIDTH-1:0] wdata,
    input  logic                   arvalid,
    output logic                   arready,
    input  logic [pADDR_WIDTH-1:0] araddr,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [pDATA_WIDTH-1:0] rdata,
    input  logic [pDATA_WIDTH-1:0] i_tap_Do,
    input  logic [pDATA_WIDTH-1:0] i_rd_data,
    input  logic                   i_rd_bram,
    output logic                   o_wr_en_c,
    output logic [pADDR_WIDTH-1:0] o_wr_addr_c,
    output logic [pDATA_WIDTH-1:0] o_wdata_c,
    output logic                   o_rd_go_c,
    output logic [pADDR_WIDTH-1:0] o_rd_go_addr_c,
    output logic                   o_rd_en_c,
    output logic [pADDR_WIDTH-1:0] o_rd_addr,
    output logic                   o_rd_done_c
);

    logic                   r_awready;
    logic                   r_arready;
    logic                   r_rvalid;
    logic                   r_rd_bram;
    logic [pDATA_WIDTH-1:0] r_rdata;
    logic [pADDR_WIDTH-1:0] r_rd_addr;
    logic                   w_wr_go;

    // A pending or just-accepted write holds off the read grant so the tap
    // write reaches the BRAM before the read address does.
    assign w_wr_go        = awvalid && wvalid && !r_awready;
    assign o_wr_en_c      = r_awready && awvalid && wvalid;
    assign o_wr_addr_c    = awaddr;
    assign o_wdata_c      = wdata;
    assign o_rd_go_c      = arvalid && !r_arready && !r_rvalid && !w_wr_go && !o_wr_en_c;
    assign o_rd_go_addr_c = araddr;
    assign o_rd_en_c      = r_arready && arvalid;
    assign o_rd_addr      = r_rd_addr;
    assign o_rd_done_c    = r_rvalid && rready;

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            r_awready <= 1'b0;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rd_bram <= 1'b0;
            r_rdata   <= '0;
            r_rd_addr <= '0;
        end else begin
            r_awready <= w_wr_go;
            r_arready <= o_rd_go_c;
            if (o_rd_go_c) begin
                r_rd_addr <= araddr;
            end
            if (o_rd_en_c) begin
                r_rvalid  <= 1'b1;
                r_rdata   <= i_rd_data;
                r_rd_bram <= i_rd_bram;
            end else begin
                // BRAM data is live for one cycle only; capture it for the hold
                if (r_rd_bram) begin
                    r_rdata   <= i_tap_Do;
                    r_rd_bram <= 1'b0;
                end
                if (o_rd_done_c) begin
                    r_rvalid <= 1'b0;
                end
            end
        end
    end

    assign awready = r_awready;
    assign wready  = r_awready;
    assign arready = r_arready;
    assign rvalid  = r_rvalid;
    assign rdata   = r_rd_bram ? i_tap_Do : r_rdata;

endmodule

// File: rtl/fir_ctrl.sv
// FIR control/status block: register map, run sequencer and tap BRAM port
// ownership. Define FIR_CTRL_IRQ_EN to add the irq port and register 0x04.
module fir_ctrl
    import fir_pkg::*;
#(
    parameter int unsigned pADDR_WIDTH = 12,
    parameter int unsigned pDATA_WIDTH = 32,
    parameter int unsigned Tape_Num    = 11
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [pADDR_WIDTH-1:0] awaddr,
    input  logic                   wvalid,
    output logic                   wready,
    input  logic [pDATA_WIDTH-1:0] wdata,
    input  logic                   arvalid,
    output logic                   arready,
    input  logic [pADDR_WIDTH-1:0] araddr,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [pDATA_WIDTH-1:0] rdata,
    output logic [3:0]             tap_WE,
    output logic                   tap_EN,
    output logic [pDATA_WIDTH-1:0] tap_Di,
    output logic [pADDR_WIDTH-1:0] tap_A,
    input  logic [pDATA_WIDTH-1:0] tap_Do,
    input  logic [pADDR_WIDTH-1:0] eng_tap_A,
    output logic                   eng_start,
    output logic                   eng_busy,
    input  logic                   out_beat,
    output logic                   out_last
`ifdef FIR_CTRL_IRQ_EN
    ,
    output logic                   irq
`endif
);

    localparam int unsigned TAP_END = REG_TAP_BASE + 4 * Tape_Num;

    logic                   w_wr_en, w_rd_go, w_rd_en, w_rd_done, w_rd_bram;
    logic [pADDR_WIDTH-1:0] w_wr_addr, w_rd_go_addr, w_rd_addr;
    logic [pDATA_WIDTH-1:0] w_wdata, w_rd_data;
    logic                   w_wr_tap, w_rd_go_tap, w_rd_tap;
    logic                   w_start_req, w_last_cnt, w_run, w_out_last;
    fir_state_e             r_state, w_state_next;
    logic [31:0]            r_data_len, r_out_cnt;
    logic                   r_eng_start, r_tap_we;
    logic [pADDR_WIDTH-1:0] r_tap_A;
    logic [pDATA_WIDTH-1:0] r_tap_Di;

    fir_ctrl_axil #(
        .pADDR_WIDTH (pADDR_WIDTH),
        .pDATA_WIDTH (pDATA_WIDTH)
    ) u_axil (
        .axis_clk       (axis_clk),
        .axis_rst_n     (axis_rst_n),
        .awvalid        (awvalid),
        .awready        (awready),
        .awaddr         (awaddr),
        .wvalid         (wvalid),
        .wready         (wready),
        .wdata          (wdata),
        .arvalid        (arvalid),
        .arready        (arready),
        .araddr         (araddr),
        .rvalid         (rvalid),
        .rready         (rready),
        .rdata          (rdata),
        .i_tap_Do       (tap_Do),
        .i_rd_data      (w_rd_data),
        .i_rd_bram      (w_rd_bram),
        .o_wr_en_c      (w_wr_en),
        .o_wr_addr_c    (w_wr_addr),
        .o_wdata_c      (w_wdata),
        .o_rd_go_c      (w_rd_go),
        .o_rd_go_addr_c (w_rd_go_addr),
        .o_rd_en_c      (w_rd_en),
        .o_rd_addr      (w_rd_addr),
        .o_rd_done_c    (w_rd_done)
    );

    assign w_wr_tap    = (32'(w_wr_addr) >= REG_TAP_BASE) && (32'(w_wr_addr) < TAP_END);
    assign w_rd_go_tap = (32'(w_rd_go_addr) >= REG_TAP_BASE) && (32'(w_rd_go_addr) < TAP_END);
    assign w_rd_tap    = (32'(w_rd_addr) >= REG_TAP_BASE) && (32'(w_rd_addr) < TAP_END);
    assign w_start_req = w_wr_en && (w_wr_addr == pADDR_WIDTH'(REG_AP_CTRL))
                         && w_wdata[AP_START_BIT] && (r_data_len != 32'd0);
    assign w_last_cnt  = (r_out_cnt == r_data_len - 32'd1);

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state; a start request from DONE goes straight back to RUN
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_start_req) w_state_next = ST_RUN;
            ST_RUN:  if (out_beat && w_last_cnt) w_state_next = ST_DONE;
            ST_DONE: begin
                if (w_start_req) begin
                    w_state_next = ST_RUN;
                end else if (w_rd_done && (w_rd_addr == pADDR_WIDTH'(REG_AP_CTRL))) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

`ifdef FIR_CTRL_IRQ_EN
    logic r_ie, r_isr, r_irq;
    logic w_ie_next, w_isr_next;

    always_comb begin
        w_ie_next  = r_ie;
        w_isr_next = r_isr;
        if (w_wr_en && (w_wr_addr == pADDR_WIDTH'(REG_IRQ))) begin
            w_ie_next = w_wdata[0];
            if (w_wdata[1]) w_isr_next = 1'b0;
        end
        if ((r_state == ST_RUN) && (w_state_next == ST_DONE)) w_isr_next = 1'b1;
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            r_ie  <= 1'b0;
            r_isr <= 1'b0;
            r_irq <= 1'b0;
        end else begin
            r_ie  <= w_ie_next;
            r_isr <= w_isr_next;
            r_irq <= w_ie_next && w_isr_next;
        end
    end

    assign irq = r_irq;
`endif

    // Status decode and register read mux
    always_comb begin
        w_run      = (r_state == ST_RUN);
        w_out_last = w_run && w_last_cnt;
        w_rd_data  = '0;
        w_rd_bram  = 1'b0;
        if (w_rd_addr == pADDR_WIDTH'(REG_AP_CTRL)) begin
            w_rd_data = pDATA_WIDTH'(ap_ctrl_val(r_state));
        end else if (w_rd_addr == pADDR_WIDTH'(REG_DATA_LEN)) begin
            w_rd_data = pDATA_WIDTH'(r_data_len);
`ifdef FIR_CTRL_IRQ_EN
        end else if (w_rd_addr == pADDR_WIDTH'(REG_IRQ)) begin
            w_rd_data = pDATA_WIDTH'({r_isr, r_ie});
`endif
        end else if (w_rd_tap) begin
            if (w_run) begin
                w_rd_data = pDATA_WIDTH'(TAP_BLOCKED_VAL);
            end else begin
                w_rd_bram = 1'b1;
            end
        end
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            r_eng_start <= 1'b0;
            r_out_cnt   <= '0;
            r_data_len  <= '0;
            r_tap_we    <= 1'b0;
            r_tap_A     <= '0;
            r_tap_Di    <= '0;
        end else begin
            r_eng_start <= (r_state != ST_RUN) && (w_state_next == ST_RUN);
            if ((r_state != ST_RUN) && (w_state_next == ST_RUN)) begin
                r_out_cnt <= '0;
            end else if (w_run && out_beat) begin
                r_out_cnt <= r_out_cnt + 32'd1;
            end
            if (w_wr_en && (w_wr_addr == pADDR_WIDTH'(REG_DATA_LEN)) && !w_run) begin
                r_data_len <= 32'(w_wdata);
            end
            r_tap_we <= w_wr_en && w_wr_tap && !w_run;
            if (w_wr_en && w_wr_tap) begin
                r_tap_A  <= w_wr_addr - pADDR_WIDTH'(REG_TAP_BASE);
                r_tap_Di <= w_wdata;
            end else if (w_rd_go && w_rd_go_tap) begin
                r_tap_A <= w_rd_go_addr - pADDR_WIDTH'(REG_TAP_BASE);
            end
        end
    end

    // The engine owns the tap port for the whole run
    assign tap_EN    = 1'b1;
    assign tap_WE    = (r_tap_we && !w_run) ? 4'hF : 4'h0;
    assign tap_A     = w_run ? eng_tap_A : r_tap_A;
    assign tap_Di    = r_tap_Di;
    assign eng_start = r_eng_start;
    assign eng_busy  = w_run;
    assign out_last  = w_out_last;

endmodule

// File: tb/tb_fir_ctrl.sv
// Scoreboard bench for fir_ctrl: reads push expected data into a queue that a
// monitor pops on every completed read beat; sequencing is checked inline.
module tb_fir_ctrl;

    localparam int unsigned AW  = 12;
    localparam int unsigned DW  = 32;
    localparam int unsigned NT  = 11;
    localparam int          LIM = 60;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } rd_exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          awvalid, wvalid, arvalid, rready, out_beat;
    logic [AW-1:0] awaddr, araddr, eng_tap_A;
    logic [DW-1:0] wdata;
    logic          awready, wready, arready, rvalid;
    logic [DW-1:0] rdata, tap_Di, tap_Do;
    logic [3:0]    tap_WE;
    logic          tap_EN;
    logic [AW-1:0] tap_A;
    logic          eng_start, eng_busy, out_last;
`ifdef FIR_CTRL_IRQ_EN
    logic          irq;
`endif

    int            n_chk = 0;
    int            n_fail = 0;
    int            we_cnt = 0;
    int            start_cnt = 0;
    rd_exp_t       exp_q[$];
    logic [DW-1:0] mem [0:4095];

    always #5 clk = ~clk;

    fir_ctrl #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(NT)) dut (
        .axis_clk   (clk),
        .axis_rst_n (rst_n),
        .awvalid    (awvalid),
        .awready    (awready),
        .awaddr     (awaddr),
        .wvalid     (wvalid),
        .wready     (wready),
        .wdata      (wdata),
        .arvalid    (arvalid),
        .arready    (arready),
        .araddr     (araddr),
        .rvalid     (rvalid),
        .rready     (rready),
        .rdata      (rdata),
        .tap_WE     (tap_WE),
        .tap_EN     (tap_EN),
        .tap_Di     (tap_Di),
        .tap_A      (tap_A),
        .tap_Do     (tap_Do),
        .eng_tap_A  (eng_tap_A),
        .eng_start  (eng_start),
        .eng_busy   (eng_busy),
        .out_beat   (out_beat),
        .out_last   (out_last)
`ifdef FIR_CTRL_IRQ_EN
        ,
        .irq        (irq)
`endif
    );

    // Tap BRAM model, byte-addressed, one-cycle read latency
    always @(posedge clk) begin
        if (tap_EN) begin
            if (tap_WE == 4'hF) mem[tap_A] <= tap_Di;
            tap_Do <= mem[tap_A];
        end
    end

    always @(negedge clk) begin
        if (tap_WE == 4'hF) we_cnt++;
        if (eng_start) start_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tmo(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL timeout waiting for %s", name);
    endtask

    // Scoreboard monitor: every completed read beat is matched against the queue
    always @(negedge clk) begin
        if (rst_n && rvalid && rready) begin
            if (exp_q.size() == 0) begin
                tmo("expected read entry");
            end else begin
                rd_exp_t e;
                e = exp_q.pop_front();
                chk($sformatf("rdata@0x%03h", e.addr), rdata, e.data);
            end
        end
    end

    task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        n = 0;
        @(posedge clk); #1;
        awvalid = 1'b1; wvalid = 1'b1; awaddr = a; wdata = d;
        while (n < LIM) begin
            @(negedge clk);
            if (awready && wready) break;
            n++;
        end
        if (n >= LIM) tmo("awready");
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic axi_read(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        exp_q.push_back(rd_exp_t'{a, d});
        @(posedge clk); #1;
        arvalid = 1'b1; araddr = a;
        n = 0;
        while (n < LIM) begin
            @(negedge clk);
            if (arready) break;
            n++;
        end
        if (n >= LIM) tmo("arready");
        @(posedge clk); #1;
        arvalid = 1'b0;
        n = 0;
        while (n < LIM) begin
            @(negedge clk);
            if (rvalid && rready) break;
            n++;
        end
        if (n >= LIM) tmo("rvalid");
        @(posedge clk); #1;
    endtask

    task automatic wait_busy();
        int n;
        n = 0;
        while (n < LIM) begin
            @(negedge clk);
            if (eng_busy) break;
            n++;
        end
        if (n >= LIM) tmo("eng_busy");
    endtask

    task automatic beats(input int n, output int lc, output int li);
        lc = 0;
        li = -1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            out_beat  = 1'b1;
            eng_tap_A = AW'(4 * (i % 11));
            @(negedge clk);
            if (out_last) begin
                lc++;
                li = i;
            end
            if (i == 0) chk("tap_A_tracks_engine", 32'(tap_A), 32'(eng_tap_A));
        end
        @(posedge clk); #1;
        out_beat = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, w0, lc, li;
        awvalid = 0; wvalid = 0; arvalid = 0; rready = 1; out_beat = 0;
        awaddr = '0; araddr = '0; wdata = '0; eng_tap_A = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", 32'(awready), 0);
        chk("rst_wready", 32'(wready), 0);
        chk("rst_arready", 32'(arready), 0);
        chk("rst_rvalid", 32'(rvalid), 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_tap_WE", 32'(tap_WE), 0);
        chk("rst_tap_A", 32'(tap_A), 0);
        chk("rst_tap_Di", tap_Di, 0);
        chk("rst_eng_start", 32'(eng_start), 0);
        chk("rst_eng_busy", 32'(eng_busy), 0);
        chk("rst_out_last", 32'(out_last), 0);
`ifdef FIR_CTRL_IRQ_EN
        chk("rst_irq", 32'(irq), 0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        axi_read(12'h000, 32'h4);
        axi_read(12'h010, 32'h0);

        // Tap load and readback, with one read held off by rready
        we_cnt = 0;
        for (int i = 0; i < 11; i++) axi_write(AW'(32'h20 + 4 * i), 32'(i + 1));
        repeat (2) @(negedge clk);
        chk("tap_WE_cycles", 32'(we_cnt), 11);
        rready = 1'b0;
        fork
            axi_read(12'h048, 32'd11);
            begin
                int n;
                n = 0;
                while (n < LIM) begin
                    @(negedge clk);
                    if (rvalid) break;
                    n++;
                end
                if (n >= LIM) tmo("rvalid_hold");
                repeat (3) @(negedge clk);
                chk("rvalid_hold", 32'(rvalid), 1);
                chk("rdata_hold", rdata, 32'd11);
                @(posedge clk); #1;
                rready = 1'b1;
            end
        join
        for (int i = 0; i < 10; i++) axi_read(AW'(32'h20 + 4 * i), 32'(i + 1));

        // Unmapped addresses
        axi_write(12'h008, 32'h1234);
        axi_read(12'h008, 32'h0);
        axi_read(12'h04C, 32'h0);
`ifndef FIR_CTRL_IRQ_EN
        axi_read(12'h004, 32'h0);
`endif

        // Write and read of the same tap issued together: read sees new value
        fork
            axi_write(12'h034, 32'h55);
            axi_read(12'h034, 32'h55);
        join

        // ap_start with zero length is ignored
        s0 = start_cnt;
        axi_write(12'h000, 32'h1);
        repeat (4) @(negedge clk);
        chk("zero_len_busy", 32'(eng_busy), 0);
        chk("zero_len_start", 32'(start_cnt - s0), 0);
        axi_read(12'h000, 32'h4);

        // Full 600-sample run
        axi_write(12'h010, 32'd600);
        axi_read(12'h010, 32'd600);
        s0 = start_cnt;
        axi_write(12'h000, 32'h1);
        wait_busy();
        beats(600, lc, li);
        @(negedge clk);
        chk("run600_start_pulses", 32'(start_cnt - s0), 1);
        chk("run600_last_count", 32'(lc), 1);
        chk("run600_last_index", 32'(li), 32'd599);
        chk("run600_busy_after", 32'(eng_busy), 0);
        axi_read(12'h000, 32'h2);
        axi_read(12'h000, 32'h4);

        // Tap and data_length accesses are blocked while running
        axi_write(12'h010, 32'd5);
        axi_write(12'h000, 32'h1);
        wait_busy();
        @(posedge clk); #1;
        eng_tap_A = 12'h01C;
        @(negedge clk);
        chk("run_tap_A", 32'(tap_A), 32'h01C);
        w0 = we_cnt;
        axi_write(12'h02C, 32'hAAAA);
        axi_read(12'h02C, 32'hFFFF_FFFF);
        axi_write(12'h010, 32'd7);
        chk("run_tap_WE_blocked", 32'(we_cnt - w0), 0);
        chk("run_still_busy", 32'(eng_busy), 1);
        beats(5, lc, li);
        chk("run5_last_index", 32'(li), 32'd4);
        axi_read(12'h000, 32'h2);
        axi_read(12'h000, 32'h4);
        axi_read(12'h02C, 32'h4);
        axi_read(12'h010, 32'd5);

        // Asynchronous reset in the middle of a run
        axi_write(12'h010, 32'd600);
        axi_write(12'h000, 32'h1);
        wait_busy();
        beats(100, lc, li);
        chk("pre_reset_no_last", 32'(lc), 0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 32'(eng_busy), 0);
        chk("async_rst_out_last", 32'(out_last), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        axi_read(12'h000, 32'h4);
        axi_read(12'h010, 32'h0);
        axi_read(12'h020, 32'h1);
        axi_read(12'h034, 32'h55);
        axi_write(12'h010, 32'd5);
        s0 = start_cnt;
        axi_write(12'h000, 32'h1);
        wait_busy();
        beats(5, lc, li);
        @(negedge clk);
        chk("rerun_last_count", 32'(lc), 1);
        chk("rerun_last_index", 32'(li), 32'd4);
        chk("rerun_busy_after", 32'(eng_busy), 0);
        chk("rerun_start_pulses", 32'(start_cnt - s0), 1);
        axi_read(12'h000, 32'h2);
        axi_read(12'h000, 32'h4);

`ifdef FIR_CTRL_IRQ_EN
        axi_write(12'h004, 32'h1);
        axi_write(12'h000, 32'h1);
        wait_busy();
        chk("irq_low_in_run", 32'(irq), 0);
        beats(5, lc, li);
        @(negedge clk);
        chk("irq_on_done", 32'(irq), 1);
        axi_read(12'h004, 32'h3);
        axi_write(12'h004, 32'h2);
        @(negedge clk);
        chk("irq_cleared", 32'(irq), 0);
        axi_read(12'h000, 32'h2);
        axi_read(12'h000, 32'h4);
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
